// File: rtl/ftransform_pipe.sv
// Two-stage streaming 4x4 forward transform: integer DCT of (src - ref) or WHT of luma DCs.
// S1 registers the row pass, S2 registers the column pass and drives out_*; ref pixels arrive on ref_pix (ref is a reserved word).
module ftransform_pipe #(
    parameter int I_WIDTH   = 8,
    parameter int C_WIDTH   = 12,
    parameter int O_WIDTH   = 16,
    parameter int TAG_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    input  logic [16*I_WIDTH-1:0]  src,
    input  logic [16*I_WIDTH-1:0]  ref_pix,
    input  logic [16*C_WIDTH-1:0]  dc_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [16*O_WIDTH-1:0]  out_coef,
    output logic                   out_mode,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic                   out_nz,
    output logic [15:0]            blk_cnt
);

    // Row results need I_WIDTH+6 bits for the DCT and C_WIDTH+2 bits for the WHT.
    localparam int S1_W = (I_WIDTH + 6 > C_WIDTH + 2) ? I_WIDTH + 6 : C_WIDTH + 2;
    localparam int AW   = 48;

    typedef logic signed [AW-1:0] wide_t;

    logic                  adv2;
    logic                  accept;
    logic                  s1_valid_reg;
    logic                  s1_mode_reg;
    logic [TAG_WIDTH-1:0]  s1_tag_reg;
    logic [16*S1_W-1:0]    s1_t_reg;
    logic [16*S1_W-1:0]    row_next;
    logic [16*O_WIDTH-1:0] col_next;

    function automatic wide_t pix(input logic [I_WIDTH-1:0] p);
        return wide_t'({{(AW-I_WIDTH){1'b0}}, p});
    endfunction

    function automatic wide_t dcx(input logic [C_WIDTH-1:0] p);
        return wide_t'({{(AW-C_WIDTH){p[C_WIDTH-1]}}, p});
    endfunction

    function automatic wide_t s1x(input logic [S1_W-1:0] p);
        return wide_t'({{(AW-S1_W){p[S1_W-1]}}, p});
    endfunction

    assign adv2     = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid_reg || adv2);
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            wide_t d0, d1, d2, d3, da0, da1, da2, da3, dt0, dt1, dt2, dt3;
            wide_t x0, x1, x2, x3, wa0, wa1, wa2, wa3, wt0, wt1, wt2, wt3;

            assign d0 = pix(src[I_WIDTH*(4*gi+0) +: I_WIDTH]) - pix(ref_pix[I_WIDTH*(4*gi+0) +: I_WIDTH]);
            assign d1 = pix(src[I_WIDTH*(4*gi+1) +: I_WIDTH]) - pix(ref_pix[I_WIDTH*(4*gi+1) +: I_WIDTH]);
            assign d2 = pix(src[I_WIDTH*(4*gi+2) +: I_WIDTH]) - pix(ref_pix[I_WIDTH*(4*gi+2) +: I_WIDTH]);
            assign d3 = pix(src[I_WIDTH*(4*gi+3) +: I_WIDTH]) - pix(ref_pix[I_WIDTH*(4*gi+3) +: I_WIDTH]);

            assign da0 = d0 + d3;
            assign da1 = d1 + d2;
            assign da2 = d1 - d2;
            assign da3 = d0 - d3;
            assign dt0 = (da0 + da1) <<< 3;
            assign dt1 = (da2 * 2217 + da3 * 5352 + 1812) >>> 9;
            assign dt2 = (da0 - da1) <<< 3;
            assign dt3 = (da3 * 2217 - da2 * 5352 + 937) >>> 9;

            assign x0 = dcx(dc_in[C_WIDTH*(4*gi+0) +: C_WIDTH]);
            assign x1 = dcx(dc_in[C_WIDTH*(4*gi+1) +: C_WIDTH]);
            assign x2 = dcx(dc_in[C_WIDTH*(4*gi+2) +: C_WIDTH]);
            assign x3 = dcx(dc_in[C_WIDTH*(4*gi+3) +: C_WIDTH]);

            assign wa0 = x0 + x2;
            assign wa1 = x1 + x3;
            assign wa2 = x1 - x3;
            assign wa3 = x0 - x2;
            assign wt0 = wa0 + wa1;
            assign wt1 = wa3 + wa2;
            assign wt2 = wa3 - wa2;
            assign wt3 = wa0 - wa1;

            assign row_next[S1_W*(4*gi+0) +: S1_W] = in_mode ? wt0[S1_W-1:0] : dt0[S1_W-1:0];
            assign row_next[S1_W*(4*gi+1) +: S1_W] = in_mode ? wt1[S1_W-1:0] : dt1[S1_W-1:0];
            assign row_next[S1_W*(4*gi+2) +: S1_W] = in_mode ? wt2[S1_W-1:0] : dt2[S1_W-1:0];
            assign row_next[S1_W*(4*gi+3) +: S1_W] = in_mode ? wt3[S1_W-1:0] : dt3[S1_W-1:0];
        end

        for (gi = 0; gi < 4; gi++) begin : g_col
            wide_t ta, tb, tc, td;
            wide_t ca0, ca1, ca2, ca3, co0, co1, co2, co3;
            wide_t ha0, ha1, ha2, ha3, ho0, ho1, ho2, ho3;

            assign ta = s1x(s1_t_reg[S1_W*(gi+0)  +: S1_W]);
            assign tb = s1x(s1_t_reg[S1_W*(gi+4)  +: S1_W]);
            assign tc = s1x(s1_t_reg[S1_W*(gi+8)  +: S1_W]);
            assign td = s1x(s1_t_reg[S1_W*(gi+12) +: S1_W]);

            assign ca0 = ta + td;
            assign ca1 = tb + tc;
            assign ca2 = tb - tc;
            assign ca3 = ta - td;
            assign co0 = (ca0 + ca1 + 7) >>> 4;
            // The +1 on any nonzero a3 is part of the codec's bit-exact definition.
            assign co1 = ((ca2 * 2217 + ca3 * 5352 + 12000) >>> 16) + ((ca3 != 0) ? wide_t'(1) : wide_t'(0));
            assign co2 = (ca0 - ca1 + 7) >>> 4;
            assign co3 = (ca3 * 2217 - ca2 * 5352 + 51000) >>> 16;

            assign ha0 = ta + tc;
            assign ha1 = tb + td;
            assign ha2 = tb - td;
            assign ha3 = ta - tc;
            assign ho0 = (ha0 + ha1) >>> 1;
            assign ho1 = (ha3 + ha2) >>> 1;
            assign ho2 = (ha3 - ha2) >>> 1;
            assign ho3 = (ha0 - ha1) >>> 1;

            assign col_next[O_WIDTH*(gi+0)  +: O_WIDTH] = s1_mode_reg ? ho0[O_WIDTH-1:0] : co0[O_WIDTH-1:0];
            assign col_next[O_WIDTH*(gi+4)  +: O_WIDTH] = s1_mode_reg ? ho1[O_WIDTH-1:0] : co1[O_WIDTH-1:0];
            assign col_next[O_WIDTH*(gi+8)  +: O_WIDTH] = s1_mode_reg ? ho2[O_WIDTH-1:0] : co2[O_WIDTH-1:0];
            assign col_next[O_WIDTH*(gi+12) +: O_WIDTH] = s1_mode_reg ? ho3[O_WIDTH-1:0] : co3[O_WIDTH-1:0];
        end
    endgenerate

    // S1 payload needs no reset: it is only observed behind s1_valid_reg.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_t_reg    <= row_next;
            s1_mode_reg <= in_mode;
            s1_tag_reg  <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            out_valid    <= 1'b0;
            out_coef     <= '0;
            out_mode     <= 1'b0;
            out_tag      <= '0;
            out_nz       <= 1'b0;
            blk_cnt      <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
            end
            if (adv2) begin
                out_valid <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_coef <= col_next;
                    out_mode <= s1_mode_reg;
                    out_tag  <= s1_tag_reg;
                    out_nz   <= |col_next;
                end
            end
            if (out_valid && out_ready) begin
                blk_cnt <= blk_cnt + 16'd1;
            end
        end
    end

endmodule
